// File: rtl/pvid_axis_tx.sv
// Stereo parallel-video to AXI4-Stream transmitter with a small backpressure FIFO.
// Register bus exposes enable, frame geometry and sticky status plus a frame counter.
module pvid_axis_tx #(
   parameter int AW = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ibus_cs,
   input  logic        ibus_wr,
   input  logic [7:0]  ibus_addr,
   input  logic [31:0] ibus_wrdata,
   output logic [31:0] ibus_rddata,
   input  logic        sof_in,
   input  logic        vin,
   input  logic [15:0] d1_in,
   input  logic [15:0] d2_in,
   output logic        tvalid,
   input  logic        tready,
   output logic        tuser,
   output logic        tlast,
   output logic [31:0] tdata
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DROP} state_t;

   state_t state, state_n;

   logic        vin_q, sof_q;
   logic [15:0] d1_q, d2_q;

   logic        enable;
   logic [11:0] width, height;
   logic        overflow, sof_error;
   logic [15:0] frame_count;

   logic [11:0] w_sh, h_sh, x, y, x_n, y_n, px, py, gw, gh;
   logic        start, wr_req, pix_user, pix_last, frame_end;
   logic        ovf_set, sof_err_set, frame_inc, geom_ok;

   logic [33:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   mem_count, occ;
   logic          full, wr_ok, load, mem_rd, mem_wr, bypass;
   logic [33:0]   wr_word;

   logic reg_wr;
   logic unused_wrdata;

   assign reg_wr        = ibus_cs & ibus_wr;
   assign unused_wrdata = ^ibus_wrdata[31:12];
   assign geom_ok       = enable & (width != 12'd0) & (height != 12'd0);

   // Inputs are registered once so every downstream decision sees clean timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vin_q <= 1'b0;
         sof_q <= 1'b0;
         d1_q  <= '0;
         d2_q  <= '0;
      end else begin
         vin_q <= vin;
         sof_q <= sof_in & vin;
         d1_q  <= d1_in;
         d2_q  <= d2_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable      <= 1'b0;
         width       <= '0;
         height      <= '0;
         overflow    <= 1'b0;
         sof_error   <= 1'b0;
         frame_count <= '0;
         ibus_rddata <= '0;
      end else begin
         if (reg_wr && ibus_addr == 8'h00) enable <= ibus_wrdata[0];
         if (reg_wr && ibus_addr == 8'h04) width  <= ibus_wrdata[11:0];
         if (reg_wr && ibus_addr == 8'h08) height <= ibus_wrdata[11:0];
         // A new event wins over a simultaneous write-one-to-clear.
         if (ovf_set)
            overflow <= 1'b1;
         else if (reg_wr && ibus_addr == 8'h0C && ibus_wrdata[0])
            overflow <= 1'b0;
         if (sof_err_set)
            sof_error <= 1'b1;
         else if (reg_wr && ibus_addr == 8'h0C && ibus_wrdata[1])
            sof_error <= 1'b0;
         if (frame_inc) frame_count <= frame_count + 16'd1;
         if (ibus_cs && !ibus_wr) begin
            case (ibus_addr)
               8'h00:   ibus_rddata <= {31'd0, enable};
               8'h04:   ibus_rddata <= {20'd0, width};
               8'h08:   ibus_rddata <= {20'd0, height};
               8'h0C:   ibus_rddata <= {frame_count, 14'd0, sof_error, overflow};
               default: ibus_rddata <= '0;
            endcase
         end
      end
   end

   always_comb begin
      state_n     = state;
      start       = 1'b0;
      wr_req      = 1'b0;
      sof_err_set = 1'b0;
      ovf_set     = 1'b0;
      frame_inc   = 1'b0;
      px          = x;
      py          = y;
      gw          = w_sh;
      gh          = h_sh;
      x_n         = x;
      y_n         = y;
      case (state)
         S_ACTIVE: begin
            if (vin_q) begin
               if (sof_q && (x != 12'd0 || y != 12'd0)) begin
                  sof_err_set = 1'b1;
                  if (geom_ok) start = 1'b1;
                  else state_n = S_IDLE;
               end else begin
                  wr_req = 1'b1;
               end
            end
         end
         default: begin
            if (vin_q && sof_q && geom_ok) start = 1'b1;
         end
      endcase
      // A frame start uses the live geometry; the shadow copy takes it on the same edge.
      if (start) begin
         wr_req = 1'b1;
         px     = '0;
         py     = '0;
         gw     = width;
         gh     = height;
      end
      pix_user  = (px == 12'd0) && (py == 12'd0);
      pix_last  = (px == gw - 12'd1);
      frame_end = pix_last && (py == gh - 12'd1);
      if (wr_req) begin
         if (full) begin
            ovf_set = 1'b1;
            state_n = S_DROP;
         end else if (frame_end) begin
            frame_inc = 1'b1;
            state_n   = S_IDLE;
            x_n       = '0;
            y_n       = '0;
         end else begin
            state_n = S_ACTIVE;
            if (pix_last) begin
               x_n = '0;
               y_n = py + 12'd1;
            end else begin
               x_n = px + 12'd1;
               y_n = py;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         x     <= '0;
         y     <= '0;
         w_sh  <= '0;
         h_sh  <= '0;
      end else begin
         state <= state_n;
         x     <= x_n;
         y     <= y_n;
         if (start) begin
            w_sh <= width;
            h_sh <= height;
         end
      end
   end

   // The output register counts as one FIFO slot, so total capacity is exactly DEPTH.
   assign occ     = mem_count + {{AW{1'b0}}, tvalid};
   assign full    = (occ == (AW + 1)'(DEPTH));
   assign wr_ok   = wr_req & ~full;
   assign load    = ~tvalid | tready;
   assign mem_rd  = load & (mem_count != '0);
   assign bypass  = load & (mem_count == '0) & wr_ok;
   assign mem_wr  = wr_ok & ~bypass;
   assign wr_word = {pix_user, pix_last, d2_q, d1_q};

   always_ff @(posedge clk) begin
      if (mem_wr) mem[wptr] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         mem_count <= '0;
         tvalid    <= 1'b0;
         tuser     <= 1'b0;
         tlast     <= 1'b0;
         tdata     <= '0;
      end else begin
         if (mem_wr) wptr <= wptr + 1'b1;
         if (mem_rd) rptr <= rptr + 1'b1;
         case ({mem_wr, mem_rd})
            2'b10:   mem_count <= mem_count + 1'b1;
            2'b01:   mem_count <= mem_count - 1'b1;
            default: mem_count <= mem_count;
         endcase
         if (load) begin
            if (mem_rd) begin
               {tuser, tlast, tdata} <= mem[rptr];
               tvalid <= 1'b1;
            end else if (bypass) begin
               {tuser, tlast, tdata} <= wr_word;
               tvalid <= 1'b1;
            end else begin
               tvalid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pvid_axis_tx.sv
// Randomised and directed bench for pvid_axis_tx against a frame-level behavioural model.
module tb_pvid_axis_tx;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ibus_cs, ibus_wr;
   logic [7:0]  ibus_addr;
   logic [31:0] ibus_wrdata, ibus_rddata;
   logic        sof_in, vin;
   logic [15:0] d1_in, d2_in;
   logic        tvalid, tready, tuser, tlast;
   logic [31:0] tdata;

   pvid_axis_tx #(.AW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .ibus_cs(ibus_cs), .ibus_wr(ibus_wr), .ibus_addr(ibus_addr),
      .ibus_wrdata(ibus_wrdata), .ibus_rddata(ibus_rddata),
      .sof_in(sof_in), .vin(vin), .d1_in(d1_in), .d2_in(d2_in),
      .tvalid(tvalid), .tready(tready), .tuser(tuser), .tlast(tlast), .tdata(tdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        user;
      logic        last;
      logic [31:0] data;
   } beat_t;

   beat_t exp_q[$];
   beat_t obs[$];
   int    checks = 0;
   int    errors = 0;

   // Model state: programmed registers plus where we are inside the current frame.
   bit m_en, m_active, m_ovf, m_serr;
   int m_width, m_height, m_w, m_h, m_x, m_y, m_fc;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_en = 0; m_active = 0; m_ovf = 0; m_serr = 0;
      m_width = 0; m_height = 0; m_w = 0; m_h = 0; m_x = 0; m_y = 0; m_fc = 0;
   endtask

   task automatic model_pixel(input bit sof, input logic [15:0] d1, input logic [15:0] d2);
      bit    full;
      beat_t b;
      int    p;
      full = (exp_q.size() >= DEPTH);
      if (!m_active) begin
         if (!(sof && m_en && m_width != 0 && m_height != 0)) return;
         m_w = m_width; m_h = m_height; m_x = 0; m_y = 0;
      end else if (sof && (m_x != 0 || m_y != 0)) begin
         m_serr = 1;
         if (!(m_en && m_width != 0 && m_height != 0)) begin
            m_active = 0;
            return;
         end
         m_w = m_width; m_h = m_height; m_x = 0; m_y = 0;
      end
      if (full) begin
         m_ovf = 1;
         m_active = 0;
         return;
      end
      b.user = (m_x == 0 && m_y == 0);
      b.last = (m_x == m_w - 1);
      b.data = {d2, d1};
      exp_q.push_back(b);
      m_active = 1;
      p = m_y * m_w + m_x + 1;
      if (p == m_w * m_h) begin
         m_fc = (m_fc + 1) % 65536;
         m_active = 0;
         m_x = 0; m_y = 0;
      end else begin
         m_x = p % m_w;
         m_y = p / m_w;
      end
   endtask

   function automatic logic [31:0] status_exp();
      return {m_fc[15:0], 14'd0, m_serr, m_ovf};
   endfunction

   task automatic apply_pixel(input bit sof, input logic [15:0] d1, input logic [15:0] d2);
      @(negedge clk); #1;
      vin = 1'b1; sof_in = sof; d1_in = d1; d2_in = d2;
      model_pixel(sof, d1, d2);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
         vin = 1'b0; sof_in = 1'b0;
      end
   endtask

   task automatic send_frame(input int n, input int sof_at);
      for (int i = 0; i < n; i++)
         apply_pixel(i == 0 || i == sof_at, 16'(i), 16'hA000 | 16'(i));
      idle_cycles(1);
   endtask

   task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
      @(negedge clk); #1;
      ibus_cs = 1'b1; ibus_wr = 1'b1; ibus_addr = addr; ibus_wrdata = data;
      case (addr)
         8'h00: m_en = data[0];
         8'h04: m_width = int'(data[11:0]);
         8'h08: m_height = int'(data[11:0]);
         8'h0C: begin
            if (data[0]) m_ovf = 0;
            if (data[1]) m_serr = 0;
         end
         default: ;
      endcase
      @(negedge clk); #1;
      ibus_cs = 1'b0; ibus_wr = 1'b0;
   endtask

   task automatic read_reg(input logic [7:0] addr, output logic [31:0] data);
      @(negedge clk); #1;
      ibus_cs = 1'b1; ibus_wr = 1'b0; ibus_addr = addr;
      @(negedge clk); #1;
      ibus_cs = 1'b0;
      @(posedge clk); #1;
      data = ibus_rddata;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      idle_cycles(4);
      check_output(name, 64'(exp_q.size()), 64'd0);
   endtask

   // Single compare process: every transfer against the model, plus AXIS hold rules.
   initial begin : compare
      beat_t prev, cur, e;
      bit    stall;
      stall = 0;
      prev  = '0;
      forever begin
         @(negedge clk); #3;
         if (!rst_n) begin
            stall = 0;
            continue;
         end
         cur = {tuser, tlast, tdata};
         if (stall) begin
            check_output("axis_hold_valid", 64'(tvalid), 64'd1);
            check_output("axis_hold_data", 64'(cur), 64'(prev));
         end
         if (tvalid && tready) begin
            obs.push_back(cur);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat actual=%h expected=none", cur);
            end else begin
               e = exp_q.pop_front();
               check_output("beat", 64'(cur), 64'(e));
            end
         end
         stall = tvalid && !tready;
         prev  = cur;
      end
   end

   initial begin : stim
      logic [31:0] rd;
      int base, n, cnt, w, h;
      bit rand_on;

      rst_n = 1'b0; ibus_cs = 0; ibus_wr = 0; ibus_addr = 0; ibus_wrdata = 0;
      vin = 0; sof_in = 0; d1_in = 0; d2_in = 0; tready = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check_output("rst_tvalid", 64'(tvalid), 64'd0);
      check_output("rst_tuser", 64'(tuser), 64'd0);
      check_output("rst_tlast", 64'(tlast), 64'd0);
      check_output("rst_tdata", 64'(tdata), 64'd0);
      check_output("rst_rddata", 64'(ibus_rddata), 64'd0);
      #1 rst_n = 1'b1;

      // Basic 4x2 frame at full throughput.
      write_reg(8'h04, 32'd4);
      write_reg(8'h08, 32'd2);
      write_reg(8'h00, 32'd1);
      base = obs.size();
      send_frame(8, -1);
      wait_drain("t1_drain");
      check_output("t1_count", 64'(obs.size() - base), 64'd8);
      check_output("t1_user0", 64'(obs[base].user), 64'd1);
      check_output("t1_user1", 64'(obs[base+1].user), 64'd0);
      check_output("t1_last3", 64'(obs[base+3].last), 64'd1);
      check_output("t1_last2", 64'(obs[base+2].last), 64'd0);
      check_output("t1_last7", 64'(obs[base+7].last), 64'd1);
      check_output("t1_data2", 64'(obs[base+2].data), 64'h0000_0000_A002_0002);
      read_reg(8'h0C, rd);
      check_output("t1_status", 64'(rd), 64'h0000_0000_0001_0000);

      // Same frame with a 10-cycle stall while beat 2 is presented.
      base = obs.size();
      fork
         send_frame(8, -1);
         begin
            n = 0;
            while (n < 200) begin
               @(negedge clk); #2;
               if (tvalid && obs.size() == base + 2) break;
               n++;
            end
            check_output("t2_stall_reached", 64'(n < 200), 64'd1);
            tready = 1'b0;
            repeat (10) @(negedge clk);
            #2 tready = 1'b1;
         end
      join
      wait_drain("t2_drain");
      check_output("t2_count", 64'(obs.size() - base), 64'd8);
      check_output("t2_data2", 64'(obs[base+2].data), 64'h0000_0000_A002_0002);

      // Overflow: 40-pixel line against a stalled sink.
      tready = 1'b0;
      write_reg(8'h04, 32'd40);
      write_reg(8'h08, 32'd1);
      base = obs.size();
      send_frame(40, -1);
      idle_cycles(3);
      read_reg(8'h0C, rd);
      check_output("t3_ovf_bit", 64'(rd[0]), 64'd1);
      check_output("t3_status", 64'(rd), 64'(status_exp()));
      @(negedge clk); #2 tready = 1'b1;
      wait_drain("t3_drain");
      check_output("t3_count", 64'(obs.size() - base), 64'd32);
      cnt = 0;
      for (int i = base; i < obs.size(); i++) cnt += int'(obs[i].last);
      check_output("t3_no_tlast", 64'(cnt), 64'd0);
      write_reg(8'h0C, 32'd1);
      write_reg(8'h04, 32'd4);
      write_reg(8'h08, 32'd2);
      base = obs.size();
      send_frame(8, -1);
      wait_drain("t3_next_drain");
      check_output("t3_next_count", 64'(obs.size() - base), 64'd8);
      read_reg(8'h0C, rd);
      check_output("t3_status2", 64'(rd), 64'(status_exp()));

      // Early SOF at pixel 5 restarts the frame.
      base = obs.size();
      send_frame(13, 5);
      wait_drain("t4_drain");
      check_output("t4_count", 64'(obs.size() - base), 64'd13);
      check_output("t4_user4", 64'(obs[base+4].user), 64'd0);
      check_output("t4_user5", 64'(obs[base+5].user), 64'd1);
      read_reg(8'h0C, rd);
      check_output("t4_serr_bit", 64'(rd[1]), 64'd1);
      check_output("t4_status", 64'(rd), 64'(status_exp()));
      write_reg(8'h0C, 32'd2);
      read_reg(8'h0C, rd);
      check_output("t4_serr_clr", 64'(rd[1]), 64'd0);

      // Disabled, then zero width: nothing leaves.
      write_reg(8'h00, 32'd0);
      base = obs.size();
      send_frame(8, -1);
      wait_drain("t5a_drain");
      check_output("t5a_count", 64'(obs.size() - base), 64'd0);
      write_reg(8'h00, 32'd1);
      write_reg(8'h04, 32'd0);
      send_frame(8, -1);
      wait_drain("t5b_drain");
      check_output("t5b_count", 64'(obs.size() - base), 64'd0);
      read_reg(8'h0C, rd);
      check_output("t5_status", 64'(rd), 64'(status_exp()));

      // Random geometry, data, gaps and backpressure.
      rand_on = 1;
      fork
         begin
            for (int f = 0; f < 8; f++) begin
               w = $urandom_range(1, 6);
               h = $urandom_range(1, 4);
               write_reg(8'h04, 32'(w));
               write_reg(8'h08, 32'(h));
               if ($urandom_range(0, 1) == 1)
                  apply_pixel(1'b0, 16'($urandom), 16'($urandom));
               for (int i = 0; i < w * h; i++) begin
                  apply_pixel(i == 0, 16'($urandom), 16'($urandom));
                  idle_cycles($urandom_range(0, 2));
               end
               idle_cycles(1);
               wait_drain("rand_drain");
            end
            rand_on = 0;
         end
         begin
            while (rand_on) begin
               @(negedge clk); #2;
               tready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      #2 tready = 1'b1;
      read_reg(8'h0C, rd);
      check_output("rand_status", 64'(rd), 64'(status_exp()));

      // Reset mid-frame with queued data.
      tready = 1'b0;
      write_reg(8'h04, 32'd4);
      write_reg(8'h08, 32'd2);
      send_frame(3, -1);
      idle_cycles(2);
      check_output("t7_pre_valid", 64'(tvalid), 64'd1);
      @(negedge clk); #1 rst_n = 1'b0;
      model_reset();
      #1;
      check_output("t7_rst_outputs", 64'({tvalid, tuser, tlast, tdata}), 64'd0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      tready = 1'b1;
      read_reg(8'h00, rd);
      check_output("t7_ctrl", 64'(rd), 64'd0);
      read_reg(8'h04, rd);
      check_output("t7_width", 64'(rd), 64'd0);
      read_reg(8'h0C, rd);
      check_output("t7_status", 64'(rd), 64'd0);
      base = obs.size();
      send_frame(8, -1);
      wait_drain("t7_ignored_drain");
      check_output("t7_ignored", 64'(obs.size() - base), 64'd0);
      write_reg(8'h04, 32'd4);
      write_reg(8'h08, 32'd2);
      write_reg(8'h00, 32'd1);
      send_frame(8, -1);
      wait_drain("t7_after_drain");
      check_output("t7_after_count", 64'(obs.size() - base), 64'd8);
      read_reg(8'h0C, rd);
      check_output("t7_fc", 64'(rd), 64'h0000_0000_0001_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
